// File: rtl/rf_alu_seq_pkg.sv
// Shared types and constants for the register-file/ALU sequencer.
// Instruction layout: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2, imm8 = [7:0].
package rf_alu_seq_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;
    localparam int IMM_LSB = 0;
    localparam int FIELD_W = 4;
    localparam int IMM_W   = 8;

    typedef enum logic [3:0] {
        OP_AND  = 4'h0,
        OP_OR   = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_ANDI = 4'h4,
        OP_ORI  = 4'h5,
        OP_ADDI = 4'h6,
        OP_SUBI = 4'h7,
        OP_LDI  = 4'h8,
        OP_CMP  = 4'h9
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        EXEC2,
        DONE,
        ERR
    } state_e;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_CMP;
    endfunction

endpackage

// File: rtl/rf_alu_seq_decode.sv
// Combinational decode: instruction + execute phase -> datapath control signals.
// All controls are zero outside the execute cycles.
module rf_alu_seq_decode
    import rf_alu_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_active,
    input  logic               i_second,
    output logic [ADDR_W-1:0]  o_ra1,
    output logic [ADDR_W-1:0]  o_ra2,
    output logic [ADDR_W-1:0]  o_wa,
    output logic [DATA_W-1:0]  o_ext,
    output logic [1:0]         o_alu_ctrl,
    output logic               o_alu_src,
    output logic               o_reg_write,
    output logic               o_is_illegal,
    output logic               o_is_two_cycle
);

    logic [3:0]        w_op;
    logic [ADDR_W-1:0] w_rd;
    logic [ADDR_W-1:0] w_rs1;
    logic [ADDR_W-1:0] w_rs2;
    logic [DATA_W-1:0] w_imm;

    assign w_op  = i_instr[OPC_LSB +: FIELD_W];
    assign w_rd  = ADDR_W'(i_instr[RD_LSB  +: FIELD_W]);
    assign w_rs1 = ADDR_W'(i_instr[RS1_LSB +: FIELD_W]);
    assign w_rs2 = ADDR_W'(i_instr[RS2_LSB +: FIELD_W]);
    assign w_imm = DATA_W'(i_instr[IMM_LSB +: IMM_W]);

    assign o_is_illegal   = !is_legal_op(w_op);
    assign o_is_two_cycle = (w_op == OP_LDI);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        o_ra1       = '0;
        o_ra2       = '0;
        o_wa        = '0;
        o_ext       = '0;
        o_alu_ctrl  = ALU_AND;
        o_alu_src   = 1'b0;
        o_reg_write = 1'b0;
        if (i_active) begin
            case (w_op)
                OP_AND, OP_OR, OP_ADD, OP_SUB: begin
                    o_ra1       = w_rs1;
                    o_ra2       = w_rs2;
                    o_wa        = w_rd;
                    o_alu_ctrl  = w_op[1:0];
                    o_reg_write = 1'b1;
                end
                OP_ANDI, OP_ORI, OP_ADDI, OP_SUBI: begin
                    o_ra1       = w_rd;
                    o_wa        = w_rd;
                    o_ext       = w_imm;
                    o_alu_src   = 1'b1;
                    o_alu_ctrl  = w_op[1:0];
                    o_reg_write = 1'b1;
                end
                // LDI clears rd first, then ORs in the immediate.
                OP_LDI: begin
                    o_ra1       = w_rd;
                    o_wa        = w_rd;
                    o_alu_src   = 1'b1;
                    o_reg_write = 1'b1;
                    o_alu_ctrl  = i_second ? ALU_OR : ALU_AND;
                    o_ext       = i_second ? w_imm : '0;
                end
                OP_CMP: begin
                    o_ra1      = w_rs1;
                    o_ra2      = w_rs2;
                    o_alu_ctrl = ALU_SUB;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rf_alu_sequencer.sv
// Multi-cycle control FSM for the 16x8 register-file/ALU datapath:
// accepts instructions over valid/ready, drives 1-2 execute cycles, reports completion.
module rf_alu_sequencer
    import rf_alu_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [15:0]        instr,
    output logic               instr_ready,
    input  logic [DATA_W-1:0]  ALUResult,
    output logic [ADDR_W-1:0]  RA1,
    output logic [ADDR_W-1:0]  RA2,
    output logic [ADDR_W-1:0]  WA,
    output logic [DATA_W-1:0]  external_data_in,
    output logic [1:0]         ALUControl,
    output logic               ALUSrc,
    output logic               RegWrite,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   retired_count
);

    state_e             r_state;
    state_e             w_next;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_dec_instr;
    logic [DATA_W-1:0]  r_result;
    logic [CNT_W-1:0]   r_retired;
    logic               w_is_illegal;
    logic               w_is_two_cycle;
    logic               w_last_exec;

    // In IDLE the decoder looks at the offered instruction so legality is known at the handshake.
    assign w_dec_instr = (r_state == IDLE) ? instr : r_instr;

    rf_alu_seq_decode #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_decode (
        .i_instr        (w_dec_instr),
        .i_active       ((r_state == EXEC) || (r_state == EXEC2)),
        .i_second       (r_state == EXEC2),
        .o_ra1          (RA1),
        .o_ra2          (RA2),
        .o_wa           (WA),
        .o_ext          (external_data_in),
        .o_alu_ctrl     (ALUControl),
        .o_alu_src      (ALUSrc),
        .o_reg_write    (RegWrite),
        .o_is_illegal   (w_is_illegal),
        .o_is_two_cycle (w_is_two_cycle)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (instr_valid) w_next = w_is_illegal ? ERR : EXEC;
            EXEC:    w_next = w_is_two_cycle ? EXEC2 : DONE;
            EXEC2:   w_next = DONE;
            DONE:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_last_exec = ((r_state == EXEC) && !w_is_two_cycle) || (r_state == EXEC2);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_instr   <= '0;
            r_result  <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (instr_ready && instr_valid) r_instr <= instr;
            if (w_last_exec) begin
                r_result  <= ALUResult;
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign instr_ready   = (r_state == IDLE);
    assign done          = (r_state == DONE);
    assign err           = (r_state == ERR);
    assign result        = r_result;
    assign zero          = (r_result == '0);
    assign retired_count = r_retired;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Directed bench for rf_alu_sequencer with a behavioural 16x8 register-file/ALU datapath.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_rf_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [7:0]  ALUResult;
    logic [3:0]  RA1, RA2, WA;
    logic [7:0]  external_data_in;
    logic [1:0]  ALUControl;
    logic        ALUSrc, RegWrite;
    logic [7:0]  result;
    logic        zero, done, err;
    logic [15:0] retired_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rf_alu_sequencer #(.DATA_W(8), .ADDR_W(4), .CNT_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .instr_ready      (instr_ready),
        .ALUResult        (ALUResult),
        .RA1              (RA1),
        .RA2              (RA2),
        .WA               (WA),
        .external_data_in (external_data_in),
        .ALUControl       (ALUControl),
        .ALUSrc           (ALUSrc),
        .RegWrite         (RegWrite),
        .result           (result),
        .zero             (zero),
        .done             (done),
        .err              (err),
        .retired_count    (retired_count)
    );

    // Behavioural datapath: register file plus 2-bit-controlled ALU.
    logic [7:0] rf [16] = '{default: 8'h00};
    logic [7:0] src_a, src_b;

    always_comb begin
        src_a = rf[RA1];
        src_b = ALUSrc ? external_data_in : rf[RA2];
        case (ALUControl)
            2'b00:   ALUResult = src_a & src_b;
            2'b01:   ALUResult = src_a | src_b;
            2'b10:   ALUResult = src_a + src_b;
            default: ALUResult = src_a - src_b;
        endcase
    end

    always @(posedge clk) if (RegWrite) rf[WA] <= ALUResult;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Offer an instruction for one edge; returns at the following falling edge.
    task automatic issue(input logic [15:0] ins);
        instr_valid = 1'b1;
        instr       = ins;
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        #2;
        check("rst_ready",   32'(instr_ready),   1);
        check("rst_regwr",   32'(RegWrite),      0);
        check("rst_result",  32'(result),        0);
        check("rst_zero",    32'(zero),          1);
        check("rst_done",    32'(done),          0);
        check("rst_err",     32'(err),           0);
        check("rst_retired", 32'(retired_count), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1: LDI r3,0xA5
        check("t1_ready", 32'(instr_ready), 1);
        issue(16'h83A5);
        check("t1_e_wa",   32'(WA),               3);
        check("t1_e_ra1",  32'(RA1),              3);
        check("t1_e_rw",   32'(RegWrite),         1);
        check("t1_e_src",  32'(ALUSrc),           1);
        check("t1_e_ext",  32'(external_data_in), 8'h00);
        check("t1_e_ac",   32'(ALUControl),       0);
        check("t1_e_rdy",  32'(instr_ready),      0);
        tick();
        check("t1_e2_ac",  32'(ALUControl),       1);
        check("t1_e2_ext", 32'(external_data_in), 8'hA5);
        check("t1_e2_rw",  32'(RegWrite),         1);
        check("t1_e2_wa",  32'(WA),               3);
        tick();
        check("t1_done",   32'(done),          1);
        check("t1_result", 32'(result),        8'hA5);
        check("t1_zero",   32'(zero),          0);
        check("t1_ret",    32'(retired_count), 1);
        check("t1_d_rw",   32'(RegWrite),      0);
        tick();
        check("t1_idle_done", 32'(done),        0);
        check("t1_idle_rdy",  32'(instr_ready), 1);
        check("t1_r3",        32'(rf[3]),       8'hA5);

        // 2: LDI r2,0x5C; ADD r4=r3+r2 (wraps); SUB r5=r3-r2
        issue(16'h825C);
        tick();
        tick();
        check("t2_ldi_res", 32'(result), 8'h5C);
        tick();
        issue(16'h2432);
        check("t2_add_ra1", 32'(RA1),        3);
        check("t2_add_ra2", 32'(RA2),        2);
        check("t2_add_src", 32'(ALUSrc),     0);
        check("t2_add_ac",  32'(ALUControl), 2);
        check("t2_add_wa",  32'(WA),         4);
        tick();
        check("t2_add_done", 32'(done),   1);
        check("t2_add_res",  32'(result), 8'h01);
        tick();
        issue(16'h3532);
        check("t2_sub_ac", 32'(ALUControl), 3);
        tick();
        check("t2_sub_res", 32'(result),        8'h49);
        check("t2_ret",     32'(retired_count), 4);
        check("t2_r4",      32'(rf[4]),         8'h01);
        tick();

        // 3: ORI r3 |= 0x0F
        issue(16'h530F);
        check("t3_ra1", 32'(RA1),              3);
        check("t3_src", 32'(ALUSrc),           1);
        check("t3_ext", 32'(external_data_in), 8'h0F);
        check("t3_ac",  32'(ALUControl),       1);
        tick();
        check("t3_res", 32'(result), 8'hAF);
        tick();
        check("t3_r3",  32'(rf[3]),  8'hAF);

        // 4: CMP r3,r3
        issue(16'h9033);
        check("t4_rw",  32'(RegWrite),   0);
        check("t4_ac",  32'(ALUControl), 3);
        check("t4_ra1", 32'(RA1),        3);
        check("t4_ra2", 32'(RA2),        3);
        tick();
        check("t4_done", 32'(done),          1);
        check("t4_res",  32'(result),        8'h00);
        check("t4_zero", 32'(zero),          1);
        check("t4_rw_d", 32'(RegWrite),      0);
        check("t4_ret",  32'(retired_count), 6);
        tick();
        check("t4_r3",   32'(rf[3]), 8'hAF);

        // 5: illegal opcode, then valid held high across busy cycles
        instr_valid = 1'b1;
        instr       = 16'hF000;
        tick();
        check("t5_err",  32'(err),         1);
        check("t5_rw",   32'(RegWrite),    0);
        check("t5_rdy",  32'(instr_ready), 0);
        check("t5_done", 32'(done),        0);
        instr = 16'h6301;
        tick();
        check("t5_err_clr", 32'(err),           0);
        check("t5_rdy2",    32'(instr_ready),   1);
        check("t5_ret",     32'(retired_count), 6);
        tick();
        check("t5_exec_wa",  32'(WA),               3);
        check("t5_exec_rw",  32'(RegWrite),         1);
        check("t5_exec_ac",  32'(ALUControl),       2);
        check("t5_exec_ext", 32'(external_data_in), 8'h01);
        check("t5_exec_rdy", 32'(instr_ready),      0);
        tick();
        check("t5_done2", 32'(done),          1);
        check("t5_res",   32'(result),        8'hB0);
        check("t5_ret2",  32'(retired_count), 7);
        tick();
        check("t5_idle", 32'(instr_ready), 1);
        instr_valid = 1'b0;
        tick();
        check("t5_stay_idle", 32'(instr_ready), 1);

        // 6: reset during EXEC2 of LDI r7,0x77
        issue(16'h8777);
        check("t6_e_rw", 32'(RegWrite), 1);
        tick();
        check("t6_e2_rw", 32'(RegWrite), 1);
        #1 reset = 1'b1;
        #1;
        check("t6_rst_rw",   32'(RegWrite),      0);
        check("t6_rst_done", 32'(done),          0);
        check("t6_rst_ret",  32'(retired_count), 0);
        check("t6_rst_res",  32'(result),        0);
        check("t6_rst_zero", 32'(zero),          1);
        tick();
        tick();
        check("t6_r3_kept", 32'(rf[3]), 8'hB0);
        check("t6_r7",      32'(rf[7]), 8'h00);
        reset = 1'b0;
        tick();
        check("t6_rdy",  32'(instr_ready),   1);
        check("t6_done", 32'(done),          0);
        check("t6_ret",  32'(retired_count), 0);

        // AND r1 = r3 & r2 after reset
        issue(16'h0132);
        tick();
        check("t6_and_done", 32'(done),          1);
        check("t6_and_res",  32'(result),        8'h10);
        check("t6_and_ret",  32'(retired_count), 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
